menu_level_ctrl: RTL and testbench

// - Level-select controller for the start menu: turns mouse position/button into hover flags,
//   a click-to-select handshake and a one-cycle game start pulse.
// - Sits between the mouse interface and the menu renderer/game core; its hover flags drive the

---
 rtl/menu_level_ctrl_if.sv | 41 ++++
 rtl/menu_level_ctrl.sv | 159 +++++++++++++++
 tb/tb_menu_level_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/menu_level_ctrl_if.sv
// Mouse-in / menu-state-out bundle between the menu level controller and its neighbours.
// unlock_mask exists only when MENU_LOCK_EN is defined.
interface menu_level_ctrl_if;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       mouse_left;
  logic       game_over;
  logic       level_cleared;
  logic       mouseInLevel1;
  logic       mouseInLevel2;
  logic       mouseInLevel3;
  logic       confirming;
  logic       menu_active;
  logic [1:0] level_sel;
  logic       start_pulse;
`ifdef MENU_LOCK_EN
  logic [2:0] unlock_mask;

  modport master (
    output mouse_x, mouse_y, mouse_left, game_over, level_cleared,
    input  mouseInLevel1, mouseInLevel2, mouseInLevel3, confirming, menu_active,
           level_sel, start_pulse, unlock_mask
  );
  modport slave (
    input  mouse_x, mouse_y, mouse_left, game_over, level_cleared,
    output mouseInLevel1, mouseInLevel2, mouseInLevel3, confirming, menu_active,
           level_sel, start_pulse, unlock_mask
  );
`else
  modport master (
    output mouse_x, mouse_y, mouse_left, game_over, level_cleared,
    input  mouseInLevel1, mouseInLevel2, mouseInLevel3, confirming, menu_active,
           level_sel, start_pulse
  );
  modport slave (
    input  mouse_x, mouse_y, mouse_left, game_over, level_cleared,
    output mouseInLevel1, mouseInLevel2, mouseInLevel3, confirming, menu_active,
           level_sel, start_pulse
  );
`endif
endinterface

// File: rtl/menu_level_ctrl.sv
// Start-menu level select: hover flags, click-to-select handshake, one-cycle game start pulse.
// Optional MENU_LOCK_EN: levels unlock progressively as earlier ones are cleared.
module menu_btn_hit #(
  parameter int X0 = 160,
  parameter int X1 = 480,
  parameter int Y0 = 80,
  parameter int H  = 60
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       o_hit
);
  localparam logic [10:0] LX0 = 11'(X0);
  localparam logic [10:0] LX1 = 11'(X1);
  localparam logic [10:0] LY0 = 11'(Y0);
  localparam logic [10:0] LY1 = 11'(Y0 + H);

  logic [10:0] w_x, w_y;
  assign w_x   = {1'b0, i_x};
  assign w_y   = {1'b0, i_y};
  assign o_hit = (w_x >= LX0) && (w_x < LX1) && (w_y >= LY0) && (w_y < LY1);
endmodule

module menu_level_ctrl #(
  parameter int BTN_X0      = 160,
  parameter int BTN_X1      = 480,
  parameter int BTN_Y1      = 80,
  parameter int BTN_Y2      = 200,
  parameter int BTN_Y3      = 320,
  parameter int BTN_H       = 60,
  parameter int CONFIRM_CYC = 25_000_000
) (
  input logic              clk,
  input logic              rst_n,
  menu_level_ctrl_if.slave bus
);
  localparam int NUM_BTN = 3;
  localparam int CNT_W   = $clog2(CONFIRM_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYC - 1);

  typedef enum logic [1:0] {S_MENU, S_PRESSED, S_CONFIRM, S_PLAYING} state_t;

  state_t             r_state;
  logic [NUM_BTN-1:0] w_hit, w_en, r_hover;
  logic [2:0]         r_sync;
  logic               w_press, w_release, w_sel_ok;
  logic [1:0]         w_hit_idx, r_cand, r_level_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_confirming, r_menu_active, r_start_pulse;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    localparam int Y0 = (g == 0) ? BTN_Y1 : (g == 1) ? BTN_Y2 : BTN_Y3;
    menu_btn_hit #(.X0(BTN_X0), .X1(BTN_X1), .Y0(Y0), .H(BTN_H)) u_hit (
      .i_x  (bus.mouse_x),
      .i_y  (bus.mouse_y),
      .o_hit(w_hit[g])
    );
  end

  // Buttons never overlap, so a priority encode is just a one-hot to index.
  always_comb begin
    w_hit_idx = 2'd0;
    if      (w_hit[0]) w_hit_idx = 2'd1;
    else if (w_hit[1]) w_hit_idx = 2'd2;
    else if (w_hit[2]) w_hit_idx = 2'd3;
  end

`ifdef MENU_LOCK_EN
  logic [2:0] r_unlock;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unlock <= 3'b001;
    end else if (r_state == S_PLAYING && bus.level_cleared) begin
      if      (r_level_sel == 2'd1) r_unlock[1] <= 1'b1;
      else if (r_level_sel == 2'd2) r_unlock[2] <= 1'b1;
    end
  end
  assign w_en            = r_unlock;
  assign bus.unlock_mask = r_unlock;
`else
  logic w_unused;
  assign w_unused = bus.level_cleared;
  assign w_en     = '1;
`endif

  assign w_sel_ok = (w_hit_idx != 2'd0) && w_en[w_hit_idx - 2'd1];

  // [0],[1] synchronise the raw button; [2] holds the previous synced value for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[1:0], bus.mouse_left};
  end
  assign w_press   =  r_sync[1] & ~r_sync[2];
  assign w_release = ~r_sync[1] &  r_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hover <= '0;
    else        r_hover <= (r_state == S_MENU || r_state == S_PRESSED) ? w_hit : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_MENU;
      r_cand        <= 2'd0;
      r_level_sel   <= 2'd0;
      r_cnt         <= '0;
      r_confirming  <= 1'b0;
      r_menu_active <= 1'b0;
      r_start_pulse <= 1'b0;
    end else begin
      r_start_pulse <= 1'b0;
      r_menu_active <= 1'b1;
      case (r_state)
        S_MENU: begin
          if (w_press && w_sel_ok) begin
            r_state <= S_PRESSED;
            r_cand  <= w_hit_idx;
          end
        end
        S_PRESSED: begin
          if (w_release) begin
            if (w_hit_idx == r_cand) begin
              r_state      <= S_CONFIRM;
              r_level_sel  <= r_cand;
              r_cnt        <= '0;
              r_confirming <= 1'b1;
            end else begin
              r_state <= S_MENU;
            end
          end
        end
        S_CONFIRM: begin
          // Counter holds at terminal count; the state change is the only exit.
          if (r_cnt == CNT_LAST) begin
            r_state       <= S_PLAYING;
            r_confirming  <= 1'b0;
            r_menu_active <= 1'b0;
            r_start_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PLAYING: begin
          r_menu_active <= bus.game_over;
          if (bus.game_over) r_state <= S_MENU;
        end
        default: r_state <= S_MENU;
      endcase
    end
  end

  assign bus.mouseInLevel1 = r_hover[0];
  assign bus.mouseInLevel2 = r_hover[1];
  assign bus.mouseInLevel3 = r_hover[2];
  assign bus.confirming    = r_confirming;
  assign bus.menu_active   = r_menu_active;
  assign bus.level_sel     = r_level_sel;
  assign bus.start_pulse   = r_start_pulse;
endmodule

// File: tb/tb_menu_level_ctrl.sv
// Bench for menu_level_ctrl: directed menu scenarios plus randomized hover/click traffic
// checked against a click-level model of the menu.
module tb_menu_level_ctrl;
  logic clk, rst_n;
  menu_level_ctrl_if bus();

  menu_level_ctrl #(.CONFIRM_CYC(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int conf_cnt  = 0;
  int exp_level = 0;
  logic [2:0] exp_unlock;

`ifdef MENU_LOCK_EN
  localparam logic [2:0] UNLOCK_RST = 3'b001;
`else
  localparam logic [2:0] UNLOCK_RST = 3'b111;
`endif

  always @(posedge clk) begin
    if (bus.start_pulse === 1'b1) pulse_cnt++;
    if (bus.confirming  === 1'b1) conf_cnt++;
  end

  function automatic int btn_of(int x, int y);
    if (x < 160 || x >= 480) return 0;
    if (y >= 80  && y < 140) return 1;
    if (y >= 200 && y < 260) return 2;
    if (y >= 320 && y < 380) return 3;
    return 0;
  endfunction

  function automatic logic [2:0] hov_of(int x, int y);
    int b;
    b = btn_of(x, y);
    return (b == 0) ? 3'b000 : 3'(1 << (b - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(int x, int y);
    bus.mouse_x = 10'(x);
    bus.mouse_y = 10'(y);
  endtask

  task automatic rand_pos(output int x, output int y);
    int k, base;
    k = int'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: x = 159; 1: x = 160; 2: x = 479; 3: x = 480;
      default: x = int'($urandom_range(0, 639));
    endcase
    base = (k == 1) ? 80 : (k == 2) ? 200 : (k == 3) ? 320 : int'($urandom_range(1, 400));
    case ($urandom_range(0, 5))
      0: y = base - 1; 1: y = base; 2: y = base + 59; 3: y = base + 60;
      default: y = base + int'($urandom_range(0, 59));
    endcase
  endtask

  task automatic apply_reset();
    bus.mouse_left = 1'b0; bus.game_over = 1'b0; bus.level_cleared = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_level = 0; exp_unlock = UNLOCK_RST;
    tick();
  endtask

  // One full press/release gesture starting from the menu; model decides its outcome.
  task automatic click(int px, int py, int rx, int ry);
    int k, r, pb, cb;
    bit ok;
    k = btn_of(px, py); r = btn_of(rx, ry);
    ok = (k != 0) && exp_unlock[k-1] && (r == k);
    pb = pulse_cnt; cb = conf_cnt;
    set_pos(px, py); bus.mouse_left = 1'b1;
    repeat (4) tick();
    n_checks++;
    if ({bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1} !== hov_of(px, py)) begin
      n_fail++; $display("FAIL click_hover got=%b exp=%b", {bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1}, hov_of(px, py));
    end
    set_pos(rx, ry); bus.mouse_left = 1'b0;
    repeat (12) tick();
    if (ok) exp_level = k;
    n_checks++;
    if (pulse_cnt - pb != int'(ok)) begin
      n_fail++; $display("FAIL click_pulses got=%0d exp=%0d (press %0d,%0d rel %0d,%0d)", pulse_cnt - pb, int'(ok), px, py, rx, ry);
    end
    n_checks++;
    if (conf_cnt - cb != (ok ? 4 : 0)) begin
      n_fail++; $display("FAIL click_confirm_cycles got=%0d exp=%0d", conf_cnt - cb, ok ? 4 : 0);
    end
    n_checks++;
    if (bus.level_sel !== 2'(exp_level)) begin
      n_fail++; $display("FAIL click_level_sel got=%0d exp=%0d", bus.level_sel, exp_level);
    end
    n_checks++;
    if (bus.menu_active !== !ok) begin
      n_fail++; $display("FAIL click_menu_active got=%b exp=%b", bus.menu_active, !ok);
    end
  endtask

  task automatic end_game(bit clr);
    bus.game_over = 1'b1; bus.level_cleared = clr;
    tick();
    bus.game_over = 1'b0; bus.level_cleared = 1'b0;
`ifdef MENU_LOCK_EN
    if (clr && exp_level < 3) exp_unlock[exp_level] = 1'b1;
    n_checks++;
    if (bus.unlock_mask !== exp_unlock) begin
      n_fail++; $display("FAIL unlock_mask got=%b exp=%b", bus.unlock_mask, exp_unlock);
    end
`endif
    n_checks++;
    if (bus.menu_active !== 1'b1 || bus.level_sel !== 2'(exp_level)) begin
      n_fail++; $display("FAIL game_over_return active=%b level=%0d exp_level=%0d", bus.menu_active, bus.level_sel, exp_level);
    end
    set_pos(300, 340);
    repeat (2) tick();
    n_checks++;
    if ({bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1} !== 3'b100) begin
      n_fail++; $display("FAIL hover_resume got=%b exp=100", {bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1});
    end
  endtask

  task automatic test_reset();
    set_pos(300, 100);
    bus.mouse_left = 1'b0; bus.game_over = 1'b0; bus.level_cleared = 1'b0;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1, bus.confirming,
         bus.menu_active, bus.level_sel, bus.start_pulse} !== 8'b0) begin
      n_fail++; $display("FAIL reset_outputs hover=%b conf=%b act=%b lvl=%0d sp=%b exp=all zero",
        {bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1}, bus.confirming, bus.menu_active, bus.level_sel, bus.start_pulse);
    end
    rst_n = 1'b1;
    exp_level = 0; exp_unlock = UNLOCK_RST;
    repeat (2) tick();
    n_checks++;
    if ({bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1} !== 3'b001 || bus.menu_active !== 1'b1
        || bus.level_sel !== 2'd0) begin
      n_fail++; $display("FAIL reset_hover hover=%b act=%b lvl=%0d exp=001/1/0",
        {bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1}, bus.menu_active, bus.level_sel);
    end
`ifdef MENU_LOCK_EN
    n_checks++;
    if (bus.unlock_mask !== 3'b001) begin
      n_fail++; $display("FAIL reset_unlock got=%b exp=001", bus.unlock_mask);
    end
`endif
  endtask

  task automatic test_cancel();
    click(300, 340, 300, 150);
  endtask

  task automatic test_click_l2();
    click(300, 220, 300, 220);
    if (exp_level == 2 && bus.menu_active === 1'b0) end_game(1'b0);
  endtask

  task automatic test_playing_ignores_mouse();
    int pb;
    click(300, 100, 300, 100);
    pb = pulse_cnt;
    set_pos(300, 220); bus.mouse_left = 1'b1;
    repeat (5) tick();
    n_checks++;
    if ({bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1} !== 3'b000) begin
      n_fail++; $display("FAIL playing_hover got=%b exp=000", {bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1});
    end
    bus.mouse_left = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (pulse_cnt != pb || bus.menu_active !== 1'b0 || bus.level_sel !== 2'd1) begin
      n_fail++; $display("FAIL playing_click pulses=%0d act=%b lvl=%0d exp=0/0/1", pulse_cnt - pb, bus.menu_active, bus.level_sel);
    end
    end_game(1'b0);
  endtask

  task automatic test_hover_random();
    int x, y;
    for (int i = 0; i < 30; i++) begin
      rand_pos(x, y);
      set_pos(x, y);
      tick();
      n_checks++;
      if ({bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1} !== hov_of(x, y)) begin
        n_fail++; $display("FAIL hover_rand (%0d,%0d) got=%b exp=%b", x, y,
          {bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1}, hov_of(x, y));
      end
    end
  endtask

  task automatic test_click_random();
    int px, py, rx, ry;
    for (int i = 0; i < 16; i++) begin
      rand_pos(px, py);
      if ($urandom_range(0, 1) == 1) begin rx = px; ry = py; end
      else rand_pos(rx, ry);
      // Game-over noise in the menu must not disturb anything.
      bus.game_over = 1'b1; bus.level_cleared = 1'b1; tick();
      bus.game_over = 1'b0; bus.level_cleared = 1'b0;
      click(px, py, rx, ry);
      if (bus.menu_active === 1'b0) end_game(1'($urandom_range(0, 1)));
    end
  endtask

`ifdef MENU_LOCK_EN
  task automatic test_lock();
    apply_reset();
    click(300, 220, 300, 220);
    click(300, 100, 300, 100);
    end_game(1'b1);
    click(300, 220, 300, 220);
    end_game(1'b0);
  endtask
`endif

  task automatic test_reset_confirm();
    int pb, n;
    bit seen;
    set_pos(300, 100); bus.mouse_left = 1'b1;
    repeat (4) tick();
    bus.mouse_left = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      tick(); n++;
      if (bus.confirming === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL reset_confirm_entry confirming never rose within 20 cycles");
    end
    pb = pulse_cnt;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1, bus.confirming,
         bus.menu_active, bus.level_sel, bus.start_pulse} !== 8'b0) begin
      n_fail++; $display("FAIL reset_confirm_outputs conf=%b act=%b lvl=%0d sp=%b exp=all zero",
        bus.confirming, bus.menu_active, bus.level_sel, bus.start_pulse);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    exp_level = 0; exp_unlock = UNLOCK_RST;
    repeat (12) tick();
    n_checks++;
    if (pulse_cnt != pb || bus.level_sel !== 2'd0 || bus.menu_active !== 1'b1 || bus.confirming !== 1'b0) begin
      n_fail++; $display("FAIL reset_confirm_abort pulses=%0d lvl=%0d act=%b conf=%b exp=0/0/1/0",
        pulse_cnt - pb, bus.level_sel, bus.menu_active, bus.confirming);
    end
  endtask

  initial begin
    test_reset();
    test_cancel();
    test_click_l2();
    test_playing_ignores_mouse();
    test_hover_random();
    test_click_random();
`ifdef MENU_LOCK_EN
    test_lock();
`endif
    test_reset_confirm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time budget");
    $fatal(1);
  end
endmodule
